// File: rtl/disp_bcd_scan.sv
// -----------------------------------------------------------------------------
// disp_bcd_scan
//   Captures a binary result on a load strobe. A sequential shift-add-3
//   (double-dabble) engine converts it to NDIG BCD digits. The stage then
//   drives NDIG active-low 7-segment patterns. Results that do not fit in
//   NDIG digits set ovf and show a dash on every digit.
//
// Parameters
//   WIDTH  width of the binary input value (>= 4)
//   NDIG   number of decimal digits / 7-segment outputs (1..8)
//
// Ports
//   clock  in   system clock, all logic on posedge
//   reset  in   synchronous, active-high reset
//   load   in   start strobe, sampled only while idle
//   value  in   [WIDTH-1:0] unsigned binary, captured on an accepted load
//   busy   out  conversion in progress (load ignored while high)
//   done   out  one-cycle pulse: bcd/seg/ovf were just updated
//   ovf    out  last conversion exceeded 10^NDIG-1
//   bcd    out  [4*NDIG-1:0] BCD digits, units in [3:0]
//   seg    out  [7*NDIG-1:0] digit i in [7i+6:7i], order {a..g}, active-low
//
// Optional feature
//   DISP_LZB_EN : leading-zero blanking on seg (digit 0 never blanked,
//                 the overflow dash overrides blanking, bcd unaffected).
//
// Handshake: load is accepted on a rising edge only when the FSM is IDLE.
//   busy rises on that same edge and stays high until the edge that writes
//   the results. On that edge done pulses high for one cycle. A load seen
//   while busy is dropped; it is never queued. A load held high in the
//   done cycle starts the next conversion immediately.
// -----------------------------------------------------------------------------
module disp_bcd_scan #(
   parameter int WIDTH = 20,
   parameter int NDIG  = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*NDIG-1:0]     bcd,
   output logic [7*NDIG-1:0]     seg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [WIDTH-1:0]    shift;
   logic [4*NDIG-1:0]   shadow;
   logic [4*NDIG-1:0]   shadow_adj;
   logic                ovf_acc;
   logic [CW-1:0]       count;
   logic [NDIG-1:0]     blank;
   logic [7*NDIG-1:0]   seg_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b0000001;
         4'd1:    decode = 7'b1001111;
         4'd2:    decode = 7'b0010010;
         4'd3:    decode = 7'b0000110;
         4'd4:    decode = 7'b1001100;
         4'd5:    decode = 7'b0100100;
         4'd6:    decode = 7'b0100000;
         4'd7:    decode = 7'b0001111;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0000100;
         default: decode = 7'b1111111;
      endcase
   endfunction

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load) state_next = CONV;
         // count still holds the cycles remaining, including this one
         CONV:    if (count == CW'(1)) state_next = UPDATE;
         UPDATE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Add-3 step: each digit is corrected on its own in 4 bits.
   // No carry crosses a digit boundary.
   always_comb begin
      shadow_adj = '0;
      for (int i = 0; i < NDIG; i++) begin
         shadow_adj[4*i +: 4] = (shadow[4*i +: 4] >= 4'd5) ?
                                (shadow[4*i +: 4] + 4'd3) : shadow[4*i +: 4];
      end
   end

   // Blank mask: a digit is blanked when it and every digit above it are
   // zero. Digit 0 always shows.
`ifdef DISP_LZB_EN
   always_comb begin
      logic zero_above;
      blank      = '0;
      zero_above = 1'b1;
      for (int i = NDIG - 1; i >= 0; i--) begin
         if (shadow[4*i +: 4] != 4'd0) zero_above = 1'b0;
         blank[i] = (i != 0) && zero_above;
      end
   end
`else
   assign blank = '0;
`endif

   // Segment image for the result about to be published
   always_comb begin
      seg_next = '1;
      for (int i = 0; i < NDIG; i++) begin
         if (ovf_acc)       seg_next[7*i +: 7] = 7'b1111110;
         else if (blank[i]) seg_next[7*i +: 7] = 7'b1111111;
         else               seg_next[7*i +: 7] = decode(shadow[4*i +: 4]);
      end
   end

   // Datapath and outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         shift   <= '0;
         shadow  <= '0;
         ovf_acc <= 1'b0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         bcd     <= '0;
         seg     <= '1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  shift   <= value;
                  shadow  <= '0;
                  ovf_acc <= 1'b0;
                  count   <= CW'(WIDTH);
                  busy    <= 1'b1;
               end
            end
            CONV: begin
               // The bit pushed out of the top digit means the value needs
               // more than NDIG digits.
               shadow  <= {shadow_adj[4*NDIG-2:0], shift[WIDTH-1]};
               shift   <= {shift[WIDTH-2:0], 1'b0};
               ovf_acc <= ovf_acc | shadow_adj[4*NDIG-1];
               count   <= count - CW'(1);
            end
            UPDATE: begin
               bcd  <= shadow;
               ovf  <= ovf_acc;
               seg  <= seg_next;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_disp_bcd_scan.sv
// -----------------------------------------------------------------------------
// tb_disp_bcd_scan
//   Directed test of disp_bcd_scan with two instances:
//     dut_a : defaults (WIDTH=20, NDIG=7)
//     dut_b : WIDTH=8, NDIG=2, used for the overflow boundary
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_disp_bcd_scan;

   localparam logic [6:0] S0   = 7'b0000001;
   localparam logic [6:0] S1   = 7'b1001111;
   localparam logic [6:0] S3   = 7'b0000110;
   localparam logic [6:0] S4   = 7'b1001100;
   localparam logic [6:0] S5   = 7'b0100100;
   localparam logic [6:0] S7   = 7'b0001111;
   localparam logic [6:0] S8   = 7'b0000000;
   localparam logic [6:0] S9   = 7'b0000100;
   localparam logic [6:0] DASH = 7'b1111110;
   localparam logic [6:0] OFF  = 7'b1111111;
`ifdef DISP_LZB_EN
   localparam logic [6:0] LZ   = OFF;
`else
   localparam logic [6:0] LZ   = S0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          load_a, load_b;
   logic [19:0]   value_a;
   logic [7:0]    value_b;
   logic          busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
   logic [27:0]   bcd_a;
   logic [48:0]   seg_a;
   logic [7:0]    bcd_b;
   logic [13:0]   seg_b;

   int            n_checks = 0;
   int            n_fail   = 0;

   // Clock / reset block
   always #5 clock = ~clock;

   disp_bcd_scan dut_a (
      .clock(clock), .reset(reset), .load(load_a), .value(value_a),
      .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a), .seg(seg_a)
   );

   disp_bcd_scan #(.WIDTH(8), .NDIG(2)) dut_b (
      .clock(clock), .reset(reset), .load(load_b), .value(value_b),
      .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b), .seg(seg_b)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: one-cycle load pulse; returns after the accepting edge.
   task automatic start(input int which, input logic [19:0] v);
      if (which == 0) begin load_a = 1'b1; value_a = v; end
      else            begin load_b = 1'b1; value_b = v[7:0]; end
      @(posedge clock); #1;
      load_a = 1'b0;
      load_b = 1'b0;
   endtask

   // Counts edges until done; lat = -1 when the bound expires.
   task automatic wait_done(input int which, output int lat);
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clock); #1;
         if ((which == 0 && done_a) || (which == 1 && done_b)) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int n_done;
      int first_lat;

      reset = 1'b1; load_a = 1'b0; load_b = 1'b0; value_a = '0; value_b = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_ovf",  ovf_a,  1'b0);
      check("rst_bcd",  bcd_a,  28'h0);
      check("rst_seg",  seg_a,  {7{OFF}});
      check("rst_seg_b", seg_b, {2{OFF}});
      reset = 1'b0;
      @(posedge clock); #1;

      // value 0
      start(0, 20'd0);
      check("zero_busy", busy_a, 1'b1);
      wait_done(0, lat);
      check("zero_lat",  lat, 21);
      check("zero_nobusy", busy_a, 1'b0);
      check("zero_bcd",  bcd_a, 28'h0);
      check("zero_ovf",  ovf_a, 1'b0);
      check("zero_seg",  seg_a, {LZ, LZ, LZ, LZ, LZ, LZ, S0});
      @(posedge clock); #1;
      check("done_pulse", done_a, 1'b0);
      check("hold_seg",  seg_a, {LZ, LZ, LZ, LZ, LZ, LZ, S0});

      // maximum input
      start(0, 20'd1048575);
      wait_done(0, lat);
      check("max_lat", lat, 21);
      check("max_bcd", bcd_a, 28'h1048575);
      check("max_ovf", ovf_a, 1'b0);
      check("max_seg", seg_a, {S1, S0, S4, S8, S5, S7, S5});

      // 305: interior zero never blanked
      start(0, 20'd305);
      wait_done(0, lat);
      check("v305_bcd", bcd_a, 28'h0000305);
      check("v305_seg", seg_a, {LZ, LZ, LZ, LZ, S3, S0, S5});

      // small instance: overflow boundary
      start(1, 20'd100);
      wait_done(1, lat);
      check("b100_lat", lat, 9);
      check("b100_ovf", ovf_b, 1'b1);
      check("b100_bcd", bcd_b, 8'h00);
      check("b100_seg", seg_b, {DASH, DASH});
      start(1, 20'd99);
      wait_done(1, lat);
      check("b99_ovf", ovf_b, 1'b0);
      check("b99_bcd", bcd_b, 8'h99);
      check("b99_seg", seg_b, {S9, S9});
      start(1, 20'd255);
      wait_done(1, lat);
      check("b255_ovf", ovf_b, 1'b1);
      check("b255_bcd", bcd_b, 8'h55);

      // back-to-back: load held high across the done cycle
      load_a = 1'b1; value_a = 20'd7;
      @(posedge clock); #1;
      wait_done(0, lat);
      check("b2b1_lat", lat, 21);
      check("b2b1_bcd", bcd_a, 28'h7);
      value_a = 20'd12;
      @(posedge clock); #1;
      load_a = 1'b0;
      check("b2b2_busy", busy_a, 1'b1);
      wait_done(0, lat);
      check("b2b2_lat", lat, 21);
      check("b2b2_bcd", bcd_a, 28'h12);

      // load during busy is dropped
      start(0, 20'd42);
      n_done = 0; first_lat = -1;
      for (int c = 1; c <= 60; c++) begin
         if (c == 5) begin load_a = 1'b1; value_a = 20'd77; end
         @(posedge clock); #1;
         load_a = 1'b0;
         if (done_a) begin
            n_done++;
            if (first_lat < 0) first_lat = c;
         end
      end
      check("drop_ndone", n_done, 1);
      check("drop_lat",   first_lat, 21);
      check("drop_bcd",   bcd_a, 28'h42);

      // reset mid-conversion
      start(0, 20'd999);
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort_busy", busy_a, 1'b0);
      check("abort_done", done_a, 1'b0);
      check("abort_seg",  seg_a, {7{OFF}});
      check("abort_bcd",  bcd_a, 28'h0);
      check("abort_ovf",  ovf_a, 1'b0);
      n_done = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clock); #1;
         if (done_a) n_done++;
      end
      check("abort_nodone", n_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
